// File: rtl/bcd_counter_scan_pkg.sv
// Shared constants and small helpers for the four-digit BCD counter with
// multiplexed display scan.
package bcd_counter_scan_pkg;

    localparam int         NUM_DIGITS    = 4;
    localparam int         IDX_W         = 2;
    localparam logic [3:0] BCD_MAX       = 4'd9;
    localparam logic [3:0] BCD_MIN       = 4'd0;
    localparam logic [3:0] DIGIT_SEL_RST = 4'b1110;

    // Loaded nibbles above 9 saturate so every digit stays a legal BCD value.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

    function automatic logic [3:0] sel_from_idx(input logic [IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_counter_scan_digit.sv
// Single-digit BCD up/down cell; cy_out flags a carry (up) or borrow (down)
// into the next more-significant digit during the same cycle.
module bcd_digit
    import bcd_counter_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       cy_out
);

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic       at_limit;

    assign at_limit = up ? (q_q == BCD_MAX) : (q_q == BCD_MIN);

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = bcd_clamp(d);
        end else if (en) begin
            if (up) begin
                q_d = at_limit ? BCD_MIN : q_q + 4'd1;
            end else begin
                q_d = at_limit ? BCD_MAX : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    // Only a real step that wraps this digit propagates to the next one.
    assign cy_out = en & ~load & at_limit;
    assign q      = q_q;

endmodule

// File: rtl/bcd_counter_scan.sv
// Four-digit BCD up/down counter with synchronous load, wrap pulse, and a
// free-running digit scanner for a multiplexed seven-segment display.
module bcd_counter_scan
    import bcd_counter_scan_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        ovf,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  digit_sel
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

    logic [NUM_DIGITS-1:0] step_en;
    logic [NUM_DIGITS-1:0] carry;
    logic [3:0]            digit_q [NUM_DIGITS];

    logic                  ovf_q;
    logic                  ovf_d;
    logic [PRESC_W-1:0]    presc_q;
    logic [PRESC_W-1:0]    presc_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [3:0]            sel_q;
    logic [3:0]            sel_d;
    logic                  scan_tick;

    // Carry/borrow ripples combinationally so a multi-digit roll settles in one edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_first
                assign step_en[gi] = en;
            end else begin : g_rest
                assign step_en[gi] = carry[gi-1];
            end

            bcd_digit u_digit (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (step_en[gi]),
                .up     (up),
                .load   (load),
                .d      (load_val[gi*4 +: 4]),
                .q      (digit_q[gi]),
                .cy_out (carry[gi])
            );

            assign count[gi*4 +: 4] = digit_q[gi];
        end
    endgenerate

    assign ovf_d = carry[NUM_DIGITS-1];

    always_comb begin
        scan_tick = (presc_q == PRESC_LAST);
        presc_d   = scan_tick ? '0 : presc_q + PRESC_W'(1);
        idx_d     = scan_tick ? idx_q + IDX_W'(1) : idx_q;
        sel_d     = sel_from_idx(idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            sel_q   <= DIGIT_SEL_RST;
        end else begin
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
        end
    end

    assign ovf       = ovf_q;
    assign digit_sel = sel_q;
    assign digit_bcd = count[{idx_q, 2'b00} +: 4];

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Bench for bcd_counter_scan: a table of load/step vectors, hand sequences for
// scan and async reset, then random traffic against a decimal reference model.
module tb_bcd_counter_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0;

    logic [15:0] count4, count1;
    logic        ovf4, ovf1;
    logic [3:0]  bcd4, bcd1, sel4, sel1;

    int total = 0;
    int bad = 0;

    // Reference model state: decimal value, wrap pulse, edges since reset.
    int m_val = 0;
    int m_ovf = 0;
    int m_n = 0;

    bcd_counter_scan #(.SCAN_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count4), .ovf(ovf4),
        .digit_bcd(bcd4), .digit_sel(sel4)
    );

    bcd_counter_scan #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count1), .ovf(ovf1),
        .digit_bcd(bcd1), .digit_sel(sel1)
    );

    always #5 clk = ~clk;

    function automatic int bcd_to_int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) begin
            int dg;
            dg = int'(v[i*4 +: 4]);
            if (dg > 9) dg = 9;
            r = r * 10 + dg;
        end
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int n);
        logic [15:0] r;
        int t = n;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] dec_digit(input int n, input int pos);
        int t = n;
        for (int i = 0; i < pos; i++) t = t / 10;
        return 4'(t % 10);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = 0;
            m_ovf = 0;
            m_n   = 0;
        end else begin
            m_n = m_n + 1;
            if (load) begin
                m_val = bcd_to_int(load_val);
                m_ovf = 0;
            end else if (en && up) begin
                m_ovf = (m_val == 9999) ? 1 : 0;
                m_val = (m_val + 1) % 10000;
            end else if (en) begin
                m_ovf = (m_val == 0) ? 1 : 0;
                m_val = (m_val + 9999) % 10000;
            end else begin
                m_ovf = 0;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int i4, i1;
        logic [3:0] s4, s1;
        i4 = (m_n / 4) % 4;
        i1 = m_n % 4;
        s4 = ~(4'b0001 << i4);
        s1 = ~(4'b0001 << i1);
        check("model_count4", count4, int_to_bcd(m_val));
        check("model_count1", count1, int_to_bcd(m_val));
        check("model_ovf4", 16'(ovf4), 16'(m_ovf));
        check("model_ovf1", 16'(ovf1), 16'(m_ovf));
        check("model_sel4", 16'(sel4), 16'(s4));
        check("model_sel1", 16'(sel1), 16'(s1));
        check("model_bcd4", 16'(bcd4), 16'(dec_digit(m_val, i4)));
        check("model_bcd1", 16'(bcd1), 16'(dec_digit(m_val, i1)));
    endtask

    task automatic drive(input logic l, input logic e, input logic u, input logic [15:0] v);
        load = l; en = e; up = u; load_val = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        logic        load;
        logic        en;
        logic        up;
        logic [15:0] load_val;
        logic [15:0] exp_count;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[17];
    logic [3:0] sel_tab[4];
    logic [3:0] bcd_tab[4];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0998, 16'h0998, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0999, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h1000, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h1001, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 16'hAF37, 16'h9937, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1233, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h9999, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h9999, 1'b0};
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bcd_tab = '{4'd4, 4'd3, 4'd2, 4'd1};

        // Reset held across clock edges: outputs must stay at reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count4, 16'h0000);
        check("rst_ovf", 16'(ovf4), 16'h0);
        check("rst_sel", 16'(sel4), 16'h000E);
        check("rst_bcd", 16'(bcd4), 16'h0);
        check("rst_sel1", 16'(sel1), 16'h000E);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].load_val);
            step();
            check($sformatf("vec%0d_count", i), count4, vecs[i].exp_count);
            check($sformatf("vec%0d_ovf", i), 16'(ovf4), 16'(vecs[i].exp_ovf));
        end

        // Asynchronous reset between edges while counting.
        drive(1'b0, 1'b1, 1'b1, 16'h0000);
        repeat (3) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_count", count4, 16'h0000);
        check("arst_ovf", 16'(ovf4), 16'h0);
        check("arst_sel", 16'(sel4), 16'h000E);
        check("arst_bcd", 16'(bcd4), 16'h0);
        check("arst_sel1", 16'(sel1), 16'h000E);
        check("arst_count1", count1, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h1234);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release loads; scan then walks digits 4 clocks each.
        step();
        check("first_load", count4, 16'h1234);
        check("div1_sel_after_load", 16'(sel1), 16'h000D);
        check("div1_bcd_after_load", 16'(bcd1), 16'h0003);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int n = 2; n <= 16; n++) begin
            step();
            check($sformatf("scan%0d_sel", n), 16'(sel4), 16'(sel_tab[(n / 4) % 4]));
            check($sformatf("scan%0d_bcd", n), 16'(bcd4), 16'(bcd_tab[(n / 4) % 4]));
        end

        // Single up step on a SCAN_DIV=1 edge: new digit and new index together.
        drive(1'b0, 1'b1, 1'b1, 16'h0000);
        step();
        check("div1_step_count", count1, 16'h1235);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);

        for (int c = 0; c < 400; c++) begin
            logic [15:0] v;
            case ($urandom_range(0, 3))
                0:       v = 16'h9999;
                1:       v = 16'h0000;
                2:       v = 16'h9998;
                default: v = 16'($urandom());
            endcase
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), v);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_counter_scan.md
BCD_COUNTER_SCAN -- requirements
Module: bcd_counter_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4, giving clock cycles per displayed digit (legal 1..65535).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  count enable; one count step per cycle when high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  16  four BCD digits; [3:0] = units, [15:12] = thousands.
REQ-009 count  output  16  registered four-digit BCD count value, same packing as load_val.
REQ-010 ovf  output  1  registered one-cycle pulse on wrap-around in either direction.
REQ-011 digit_bcd  output  4  BCD value of the currently scanned digit; feeds the downstream BCD-to-segment decoder.
REQ-012 digit_sel  output  4  active-low one-hot digit enable; bit n low means digit n is displayed.

Function
REQ-013 Each nibble of count SHALL always hold 0..9.
REQ-014 load SHALL take priority over en; on load, count <= load_val at the next edge, with any nibble >9 stored as 9; ovf = 0.
REQ-015 With en=1, load=0, up=1: units +1, carry ripples within the same cycle; 9 -> 0 generates carry to the next digit.
REQ-016 With en=1, load=0, up=0: units -1, borrow ripples within the same cycle; 0 -> 9 generates borrow to the next digit.
REQ-017 Wrap 9999 -> 0000 (up) or 0000 -> 9999 (down) SHALL assert ovf for exactly the cycle after the wrapping edge.
REQ-018 With en=0 and load=0, count SHALL hold and ovf SHALL be 0.
REQ-019 The count latency SHALL be one cycle: count reflects the step at the edge where en or load is sampled.
REQ-020 A prescaler SHALL count 0..SCAN_DIV-1 continuously, independent of en and load.
REQ-021 When the prescaler wraps, the 2-bit scan index SHALL advance 0->1->2->3->0.
REQ-022 If SCAN_DIV=1, the scan index SHALL advance every cycle.
REQ-023 digit_sel SHALL equal ~(4'b0001 << idx), registered.
REQ-024 digit_bcd SHALL be the nibble of count selected by idx, combinational from the registered count and idx, so it updates in the same cycle count changes.
REQ-025 A simultaneous count step and scan advance SHALL both take effect at the same edge, with no interaction between them.

Reset
REQ-026 While rst_n=0, the block SHALL hold count=16'h0000, ovf=0, prescaler=0, idx=0, digit_sel=4'b1110 and digit_bcd=4'h0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL immediately force the REQ-026 values.
REQ-028 After rst_n deasserts, the first count step or load SHALL occur on the first rising clk edge.

Structure
REQ-029 A shared package SHALL hold NUM_DIGITS=4, BCD_MAX=4'd9 and the reset digit_sel constant 4'b1110.
REQ-030 The sub-module bcd_digit SHALL be a single-digit BCD up/down cell with inputs en, up, load, d[3:0], outputs q[3:0], cy_out, instantiated NUM_DIGITS times and chained through cy_out.
REQ-031 The prescaler, scan index, digit_sel register and ovf register SHALL live in the top module.

Verification
REQ-032 Reset then load=1 with load_val=16'h0998, then en=1, up=1 for 3 cycles -> count 0999, 1000, 1001; ovf stays 0.
REQ-033 Load 16'h9999, then one up step -> count 16'h0000 and ovf=1 for one cycle; load 16'h0000, then one down step -> count 16'h9999 and ovf=1 for one cycle.
REQ-034 Load 16'hAF37 -> count 16'h9937; load=1 together with en=1 -> load wins.
REQ-035 SCAN_DIV=4 with count=16'h1234 -> digit_sel cycles 1110, 1101, 1011, 0111 (4 clocks each), with digit_bcd 4, 3, 2, 1 respectively.
REQ-036 Assert rst_n=0 asynchronously between edges while counting -> outputs reach REQ-026 values before the next clk edge.
REQ-037 SCAN_DIV=1 -> digit_sel rotates every cycle; a count step on the same edge updates digit_bcd in the same cycle.
